// File: rtl/lsu_bus_if.sv
// Load/store unit bridging the MEM stage to the data-memory bus: lane steering, extension, wait-state timeout.
// Optional: define LSU_MISALIGN_TRAP_EN to reject misaligned accesses instead of aligning them down.
module lsu_bus_if #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  resp_valid,
    output logic [DATA_W-1:0]     resp_rdata,
    output logic                  resp_err,
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic [DATA_W-1:0]     bus_rdata,
    input  logic                  bus_ack
);
    localparam int LANES = DATA_W / 8;
    localparam int OFF   = $clog2(LANES);
    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W:0] TMO_LAST = (CNT_W + 1)'(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    // Everything the load path needs once the bus answers.
    typedef struct packed {
        logic           we;
        logic [1:0]     size;
        logic           uns;
        logic [OFF-1:0] off;
    } acc_info_t;

    state_t            state, state_nxt;
    acc_info_t         cur;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W:0]    cnt_inc;
    logic              tmo, accept, illegal, req_bad;
    logic [OFF-1:0]    size_mask, off_al;
    logic [LANES-1:0]  be_base, be_nxt;
    logic [DATA_W-1:0] wdata_rep, rd_sh, rd_msk, rd_ext;
    logic              rd_sbit;

    assign req_ready  = (state == IDLE);
    assign bus_req    = (state == BUSY);
    assign resp_valid = (state == DONE);
    assign accept     = req_valid && (state == IDLE);
    assign illegal    = (req_size == 2'b11) && (DATA_W < 64);
    assign cnt_inc    = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign tmo        = (TIMEOUT_CYC != 0) && (cnt_inc == TMO_LAST);

    always_comb begin
        size_mask = '0;
        be_base   = '0;
        wdata_rep = req_wdata;
        case (req_size)
            2'd0: begin
                size_mask = '0;
                be_base   = LANES'(1);
                wdata_rep = {LANES{req_wdata[7:0]}};
            end
            2'd1: begin
                size_mask = OFF'(1);
                be_base   = LANES'(3);
                wdata_rep = {(LANES/2){req_wdata[15:0]}};
            end
            2'd2: begin
                size_mask = OFF'(3);
                be_base   = LANES'(4'hF);
                wdata_rep = {(LANES/4){req_wdata[31:0]}};
            end
            default: begin
                size_mask = '1;
                be_base   = '1;
                wdata_rep = req_wdata;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign req_bad = illegal || (|(req_addr[OFF-1:0] & size_mask));
    assign off_al  = req_addr[OFF-1:0];
`else
    assign req_bad = illegal;
    assign off_al  = req_addr[OFF-1:0] & ~size_mask;
`endif
    assign be_nxt = be_base << off_al;

    // Right-justify the addressed lanes, then extend from the access size.
    always_comb begin
        rd_sh   = bus_rdata >> {cur.off, 3'b000};
        rd_msk  = '1;
        rd_sbit = 1'b0;
        case (cur.size)
            2'd0:    begin rd_msk = DATA_W'(8'hFF);        rd_sbit = rd_sh[7];  end
            2'd1:    begin rd_msk = DATA_W'(16'hFFFF);     rd_sbit = rd_sh[15]; end
            2'd2:    begin rd_msk = DATA_W'(32'hFFFF_FFFF); rd_sbit = rd_sh[31]; end
            default: begin rd_msk = '1;                     rd_sbit = 1'b0;      end
        endcase
        rd_ext = (rd_sh & rd_msk) | ((rd_sbit && !cur.uns) ? ~rd_msk : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = req_bad ? DONE : BUSY;
            BUSY:    if (bus_ack || tmo) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur        <= '0;
            cnt        <= '0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= '0;
            bus_wdata  <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    cnt      <= '0;
                    resp_err <= req_bad;
                    if (!req_bad) begin
                        cur       <= '{we: req_we, size: req_size, uns: req_unsigned, off: off_al};
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
                        bus_be    <= be_nxt;
                        bus_wdata <= wdata_rep;
                    end
                end
                BUSY: begin
                    // Ack beats a coincident timeout.
                    if (bus_ack)      resp_rdata <= cur.we ? '0 : rd_ext;
                    else if (tmo)     resp_err   <= 1'b1;
                    else              cnt        <= cnt_inc[CNT_W-1:0];
                end
                default: begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_bus_if.sv
// Randomized self-checking bench for lsu_bus_if (DATA_W=32, TIMEOUT_CYC=4) against a byte-level model.
module tb_lsu_bus_if;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          resp_valid, resp_err;
    logic [DW-1:0] resp_rdata;
    logic          bus_req, bus_we, bus_ack;
    logic [AW-1:0] bus_addr;
    logic [3:0]    bus_be;
    logic [DW-1:0] bus_wdata, bus_rdata;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_bus_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_be(bus_be), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction; the bus acks on its (wt+1)-th request cycle unless the timeout hits first.
    task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata, input int wt);
        int nb, off, eoff, exp_lat, exp_reqc, lat, reqc;
        bit bad, got, exp_err;
        logic [31:0] exp_addr, exp_wd, exp_rd, m;
        logic [3:0]  exp_be;
        nb  = 1 << size;
        off = int'(addr % 4);
`ifdef LSU_MISALIGN_TRAP_EN
        bad  = (size == 2'd3) || ((off % nb) != 0);
        eoff = off;
`else
        bad  = (size == 2'd3);
        eoff = off - (off % nb);
`endif
        exp_addr = addr & ~32'd3;
        exp_be   = 4'(((1 << nb) - 1) << eoff);
        for (int i = 0; i < 4; i++) exp_wd[8*i +: 8] = wdata[8*(i % nb) +: 8];
        exp_rd = '0;
        if (!bad) begin
            for (int i = 0; i < nb && i < 4; i++) exp_rd[8*i +: 8] = rdata[8*(eoff+i) +: 8];
            m = (nb >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8*nb)) - 32'd1);
            if (!uns && exp_rd[8*nb-1]) exp_rd = exp_rd | ~m;
        end
        if (bad) begin
            exp_lat = 1; exp_reqc = 0; exp_err = 1'b1;
        end else if (wt < TMO) begin
            exp_lat = wt + 2; exp_reqc = wt + 1; exp_err = 1'b0;
        end else begin
            exp_lat = TMO + 1; exp_reqc = TMO; exp_err = 1'b1;
        end
        if (we || exp_err) exp_rd = '0;

        @(negedge clk);
        chk("ready_before", req_ready, 1);
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        bus_ack = 1'($urandom % 2);
        @(negedge clk);
        req_valid = 1'b0; bus_ack = 1'b0;
        lat = 1; reqc = 0; got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (resp_valid) begin got = 1'b1; break; end
            if (bus_req) begin
                if (reqc == 0) begin
                    chk("bus_addr", bus_addr, exp_addr);
                    chk("bus_be", bus_be, exp_be);
                    chk("bus_we", bus_we, we);
                    if (we) chk("bus_wdata", bus_wdata, exp_wd);
                end else begin
                    chk("bus_addr_hold", bus_addr, exp_addr);
                end
                reqc++;
            end
            bus_ack   = bus_req && (reqc == wt + 1);
            bus_rdata = bus_ack ? rdata : $urandom;
            req_valid = 1'($urandom % 2);
            req_addr  = $urandom;
            @(negedge clk);
            bus_ack = 1'b0; req_valid = 1'b0; lat++;
        end
        chk("resp_seen", got, 1);
        chk("resp_latency", lat, exp_lat);
        chk("bus_req_cycles", reqc, exp_reqc);
        chk("resp_err", resp_err, exp_err);
        chk("resp_rdata", resp_rdata, exp_rd);
        @(negedge clk);
        chk("resp_pulse", resp_valid, 0);
        chk("ready_after", req_ready, 1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; bus_rdata = '0; bus_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_bus_req", bus_req, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_be", bus_be, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_ready", req_ready, 1);

        run_txn(1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF, 0);
        run_txn(1'b0, 2'd0, 1'b0, 32'h13,  32'h0,        32'h80123456, 1);
        run_txn(1'b0, 2'd0, 1'b1, 32'h13,  32'h0,        32'h80123456, 0);
        run_txn(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234ABCD, 32'h55AA55AA, 0);
        run_txn(1'b0, 2'd2, 1'b0, 32'h10,  32'h0,        32'h12345678, 10);
        run_txn(1'b0, 2'd2, 1'b0, 32'h14,  32'h0,        32'hCAFEF00D, TMO - 1);
        run_txn(1'b0, 2'd2, 1'b0, 32'h2,   32'h0,        32'hA1B2C3D4, 0);
        run_txn(1'b0, 2'd3, 1'b0, 32'h8,   32'h0,        32'h11111111, 0);
        run_txn(1'b0, 2'd1, 1'b0, 32'h22,  32'h0,        32'h80001234, 2);

        // Reset in the middle of a bus cycle drops the response.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h20;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_bus_req", bus_req, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_ready", req_ready, 1);
        bus_ack = 1'b1; bus_rdata = 32'hFFFF0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("mid_rst_no_resp", resp_valid, 0);
            chk("mid_rst_no_req", bus_req, 0);
        end
        bus_ack = 1'b0;

        for (int n = 0; n < 150; n++) begin
            run_txn(1'($urandom % 2), 2'($urandom % 4), 1'($urandom % 2),
                    32'($urandom % 4096), $urandom, $urandom, int'($urandom % 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
